// File: rtl/ising_sweep_ctrl.sv
// ising_sweep_ctrl
// Lattice owner and sweep sequencer for the Ising Metropolis datapath.
// Holds an N x N periodic spin lattice in flops, presents one site per clock
// (centre spin, four wrapped neighbours, LFSR word) to a combinational
// evaluator and writes the returned spin back, tracking the up-spin count.
//
// Build option: define ISING_CHECKERBOARD_EN to visit all even-parity sites
// ((row+col) even, ascending index) before all odd-parity sites in each sweep.
// Without it the visit order is plain raster 0..N*N-1. Both orders take N*N
// cycles per sweep.
//
// Handshake: start is a single-cycle request sampled only in IDLE; busy is high
// for every cycle a site is being written; done is a one-cycle pulse that
// follows the last write (or follows start directly when num_sweeps is 0).
module ising_sweep_ctrl #(
  parameter int          N            = 8,
  parameter int          ADDR_W       = $clog2(N*N),
  parameter logic [11:0] SEED_DEFAULT = 12'hACE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              init_lattice,
  input  logic [7:0]        num_sweeps,
  input  logic [11:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              spin_val,
  output logic              left,
  output logic              right,
  output logic              top,
  output logic              bottom,
  output logic [11:0]       random,
  input  logic              final_spin_val,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_spin,
  output logic [ADDR_W:0]   up_count,
  output logic [1:0]        dbg_state
);

  localparam int LOG_N = $clog2(N);
  localparam int CELLS = N * N;

  localparam logic [LOG_N-1:0]  ONE_C  = {{(LOG_N-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_U  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FULL_U = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CELLS-1:0]   r_lat;
  logic [LOG_N-1:0]   r_row;
  logic [LOG_N-1:0]   r_col;
  logic               r_phase;
  logic [7:0]         r_sweeps_left;
  logic [11:0]        r_lfsr;
  logic [ADDR_W:0]    r_up;
  logic               r_busy;
  logic               r_done;

  logic [ADDR_W-1:0]  w_site;
  logic [LOG_N-1:0]   w_row_m1;
  logic [LOG_N-1:0]   w_row_p1;
  logic [LOG_N-1:0]   w_col_m1;
  logic [LOG_N-1:0]   w_col_p1;
  logic               w_old;
  logic [11:0]        w_lfsr_next;
  logic [11:0]        w_seed;
  logic [LOG_N-1:0]   w_next_row;
  logic [LOG_N-1:0]   w_next_col;
  logic               w_next_phase;
  logic               w_sweep_end;

  assign w_site   = {r_row, r_col};
  assign w_row_m1 = r_row - ONE_C;
  assign w_row_p1 = r_row + ONE_C;
  assign w_col_m1 = r_col - ONE_C;
  assign w_col_p1 = r_col + ONE_C;
  assign w_old    = r_lat[w_site];

  // x^12+x^11+x^10+x^4+1: feedback from bits 11,10,9,3 shifted into bit 0
  assign w_lfsr_next = {r_lfsr[10:0], r_lfsr[11] ^ r_lfsr[10] ^ r_lfsr[9] ^ r_lfsr[3]};
  // an all-zero seed would lock the LFSR, so it is replaced by 1
  assign w_seed      = (seed == 12'd0) ? 12'h001 : seed;

  // Site visit order: compute the next (row, col, phase) and the end-of-sweep flag
  always_comb begin
    w_next_row   = r_row;
    w_next_col   = r_col;
    w_next_phase = r_phase;
    w_sweep_end  = 1'b0;
`ifdef ISING_CHECKERBOARD_EN
    // N is even, so the last same-colour column of any row is N-2 or N-1
    if (&r_col[LOG_N-1:1]) begin
      w_next_row = w_row_p1;
      if (&r_row) begin
        // colour half finished: restart at row 0 on the other colour
        w_next_phase = ~r_phase;
        w_next_col   = {{(LOG_N-1){1'b0}}, ~r_phase};
      end else begin
        w_next_col   = {{(LOG_N-1){1'b0}}, w_row_p1[0] ^ r_phase};
      end
    end else begin
      w_next_col = r_col + {ONE_C[LOG_N-2:0], 1'b0};
    end
    w_sweep_end = r_phase & (&r_row) & (&r_col[LOG_N-1:1]);
`else
    w_next_col = w_col_p1;
    if (&r_col) begin
      w_next_row = w_row_p1;
    end
    w_sweep_end = (&r_row) & (&r_col);
`endif
  end

  // Control FSM together with lattice, LFSR, pointer and up-spin counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lat         <= '1;
      r_row         <= '0;
      r_col         <= '0;
      r_phase       <= 1'b0;
      r_sweeps_left <= 8'd0;
      r_lfsr        <= SEED_DEFAULT;
      r_up          <= FULL_U;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (num_sweeps == 8'd0) begin
              // nothing to sweep: lattice and LFSR stay untouched
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state       <= S_RUN;
              r_busy        <= 1'b1;
              r_lfsr        <= w_seed;
              r_sweeps_left <= num_sweeps;
              r_row         <= '0;
              r_col         <= '0;
              r_phase       <= 1'b0;
              if (init_lattice) begin
                r_lat <= '1;
                r_up  <= FULL_U;
              end
            end
          end
        end
        S_RUN: begin
          r_lat[w_site] <= final_spin_val;
          if (!w_old && final_spin_val) begin
            r_up <= r_up + ONE_U;
          end else if (w_old && !final_spin_val) begin
            r_up <= r_up - ONE_U;
          end
          r_lfsr  <= w_lfsr_next;
          r_row   <= w_next_row;
          r_col   <= w_next_col;
          r_phase <= w_next_phase;
          if (w_sweep_end) begin
            if (r_sweeps_left == 8'd1) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_sweeps_left <= r_sweeps_left - 8'd1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign spin_val  = r_lat[w_site];
  assign left      = r_lat[{r_row, w_col_m1}];
  assign right     = r_lat[{r_row, w_col_p1}];
  assign top       = r_lat[{w_row_m1, r_col}];
  assign bottom    = r_lat[{w_row_p1, r_col}];
  assign random    = r_lfsr;
  assign rd_spin   = r_lat[rd_addr];
  assign up_count  = r_up;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Bench for ising_sweep_ctrl: randomized sweeps driven through a bench-side
// evaluator stub, with a reference lattice model producing per-cycle and
// per-run expectations that a monitor compares as the DUT presents them.
`timescale 1ns/10ps
module tb_ising_sweep_ctrl;

  localparam int N     = 8;
  localparam int CELLS = N * N;
  localparam int AW    = 6;
  localparam int CW    = 24;   // {spin,l,r,t,b, random[11:0], up[6:0]}
  localparam int DW    = 131;  // {lat[63:0], up[6:0], lfsr[11:0], done_cyc[31:0], busy_cycles[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          start, init_lattice;
  logic [7:0]    num_sweeps;
  logic [11:0]   seed;
  logic          busy, done, spin_val, left, right, top, bottom;
  logic [11:0]   random;
  logic          final_spin_val;
  logic [AW-1:0] rd_addr, drv_addr, mon_addr;
  logic          mon_rd;
  logic          rd_spin;
  logic [AW:0]   up_count;
  logic [1:0]    dbg_state;
  int            mode = 0;

  assign rd_addr = mon_rd ? mon_addr : drv_addr;

  ising_sweep_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_lattice(init_lattice),
    .num_sweeps(num_sweeps), .seed(seed), .busy(busy), .done(done),
    .spin_val(spin_val), .left(left), .right(right), .top(top), .bottom(bottom),
    .random(random), .final_spin_val(final_spin_val), .rd_addr(rd_addr),
    .rd_spin(rd_spin), .up_count(up_count), .dbg_state(dbg_state)
  );

  // Evaluator stub: 0 flips the spin, 1 is a majority/random rule, 2 follows the random word
  function automatic logic stub_f(input int md, input logic s, input logic l, input logic r,
                                  input logic t, input logic b, input logic [11:0] rnd);
    int sum;
    sum = int'(l) + int'(r) + int'(t) + int'(b);
    case (md)
      0: return ~s;
      1: begin
        if (sum >= 3) return 1'b1;
        else if (sum <= 1) return 1'b0;
        else return rnd[0] ^ rnd[5];
      end
      default: return rnd[7];
    endcase
  endfunction

  assign final_spin_val = stub_f(mode, spin_val, left, right, top, bottom, random);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] cyc_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CELLS-1:0] m_lat;
  logic [11:0]      m_lfsr;
  int               order[CELLS];

  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    return {s[10:0], ^(s & 12'hE08)};
  endfunction

  function automatic int wrap_idx(input int row, input int col);
    return (((row % N) + N) % N) * N + (((col % N) + N) % N);
  endfunction

  task automatic build_order();
    int k;
    k = 0;
`ifdef ISING_CHECKERBOARD_EN
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < CELLS; i++)
        if (((i / N) + (i % N)) % 2 == p) begin
          order[k] = i;
          k++;
        end
`else
    for (int i = 0; i < CELLS; i++) order[i] = i;
`endif
  endtask

  // ---------------- driver ----------------
  task automatic issue(input int md, input int ns, input logic init, input logic [11:0] sd);
    int a, i, row, col;
    logic s, l, r, t, b, nv;
    @(negedge clk);
    mode = md;
    start = 1'b1;
    num_sweeps = 8'(ns);
    init_lattice = init;
    seed = sd;
    a = cyc + 1;
    if (ns > 0) begin
      if (init) m_lat = '1;
      m_lfsr = (sd == 12'd0) ? 12'h001 : sd;
      for (int sw = 0; sw < ns; sw++)
        for (int k = 0; k < CELLS; k++) begin
          i = order[k];
          row = i / N;
          col = i % N;
          s = m_lat[i];
          l = m_lat[wrap_idx(row, col - 1)];
          r = m_lat[wrap_idx(row, col + 1)];
          t = m_lat[wrap_idx(row - 1, col)];
          b = m_lat[wrap_idx(row + 1, col)];
          cyc_q.push_back({s, l, r, t, b, m_lfsr, 7'($countones(m_lat))});
          nv = stub_f(md, s, l, r, t, b, m_lfsr);
          m_lat[i] = nv;
          m_lfsr = lfsr_step(m_lfsr);
        end
    end
    exp_q.push_back({m_lat, 7'($countones(m_lat)), m_lfsr, 32'(a + ns * CELLS), 16'(ns * CELLS)});
  endtask

  // Wait for done; meanwhile throw ignored start requests with junk parameters
  task automatic wait_done(input int limit);
    bit got;
    got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
        num_sweeps = 8'($urandom_range(0, 255));
        seed = 12'($urandom_range(0, 4095));
        init_lattice = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout actual=no_done expected=done within %0d cycles", limit);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic drv_read_lattice(output logic [CELLS-1:0] v);
    for (int k = 0; k < CELLS; k++) begin
      drv_addr = AW'(k);
      #0.05;
      v[k] = rd_spin;
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [CELLS-1:0] v;
    @(negedge clk);
    chk({tag, "_up_count"}, 64'(up_count), 64'(CELLS));
    chk({tag, "_random"},   64'(random), 64'(12'hACE));
    chk({tag, "_busy"},     64'(busy), 64'(0));
    chk({tag, "_done"},     64'(done), 64'(0));
    chk({tag, "_nbrs"},     64'({spin_val, left, right, top, bottom}), 64'(5'h1f));
    drv_read_lattice(v);
    chk({tag, "_lattice"},  64'(v), 64'(m_lat));
  endtask

  // ---------------- monitor ----------------
  int busy_cnt = 0;
  always @(negedge clk) begin
    logic [CW-1:0]    ce;
    logic [DW-1:0]    de;
    logic [CELLS-1:0] v;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (cyc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL run_unexpected actual=busy expected=idle (cycle %0d)", cyc);
        end else begin
          ce = cyc_q.pop_front();
          chk("run_site", 64'({spin_val, left, right, top, bottom, random, up_count}), 64'(ce));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=done expected=no_done (cycle %0d)", cyc);
        end else begin
          de = exp_q.pop_front();
          mon_rd = 1'b1;
          for (int k = 0; k < CELLS; k++) begin
            mon_addr = AW'(k);
            #0.05;
            v[k] = rd_spin;
          end
          mon_rd = 1'b0;
          chk("done_lattice",  64'(v), 64'(de[130:67]));
          chk("done_up_count", 64'(up_count), 64'(de[66:60]));
          chk("done_random",   64'(random), 64'(de[59:48]));
          chk("done_cycle",    64'(cyc), 64'(de[47:16]));
          chk("busy_cycles",   64'(busy_cnt), 64'(de[15:0]));
          chk("busy_in_done",  64'(busy), 64'(0));
          chk("run_leftover",  64'(cyc_q.size()), 64'(0));
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int md, ns;
    logic in;
    logic [11:0] sd;
    rst_n = 1'b0;
    start = 1'b0;
    init_lattice = 1'b0;
    num_sweeps = 8'd0;
    seed = 12'd0;
    drv_addr = '0;
    mon_addr = '0;
    mon_rd = 1'b0;
    m_lat = '1;
    m_lfsr = 12'hACE;
    build_order();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    // flip-everything stub: one sweep clears, two sweeps from all-ones restore
    issue(0, 1, 1'b0, 12'h5A5); wait_done(CELLS + 20);
    issue(0, 2, 1'b1, 12'h123); wait_done(2 * CELLS + 20);
    // zero seed is replaced by 1, random runs 001, 002, ...
    issue(1, 1, 1'b0, 12'h000); wait_done(CELLS + 20);
    // zero sweeps: done next cycle, nothing changes
    issue(1, 0, 1'b0, 12'h777); wait_done(20);

    for (int n = 0; n < 10; n++) begin
      md = $urandom_range(0, 2);
      ns = $urandom_range(0, 3);
      in = (ns == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
      issue(md, ns, in, sd);
      wait_done(ns * CELLS + 20);
    end

    // abort mid-sweep with reset
    issue(2, 1, 1'b0, 12'h3C3);
    repeat (30) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    m_lat = '1;
    m_lfsr = 12'hACE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("abort");
    repeat (5) @(negedge clk);
    issue(1, 1, 1'b0, 12'h9F1); wait_done(CELLS + 20);

    repeat (3) @(negedge clk);
    chk("final_done_queue", 64'(exp_q.size()), 64'(0));
    chk("final_run_queue",  64'(cyc_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
